pipe_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers). It detects load-use hazards, squashes the fetched instruction on taken branches/jumps, and handshakes multi-cycle data-memory accesses in MEM. It drives the per-stage write-enable and bubble controls, plus a stall performance counter and a sticky memory-timeout error.

---
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for a 5-stage pipeline.
//
// Detects load-use hazards between the EX and ID stages. Squashes the fetched
// instruction on a taken branch. Handshakes multi-cycle data-memory accesses
// in MEM, with a timeout that parks the controller in a sticky error state.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   ID_*_i                register operands of the instruction in ID
//   EX_MemRead_i/RdAddr_i load flag and destination of the EX instruction
//   ID_Branch_Taken_i     branch/jump resolved taken in ID
//   MEM_MemRead/Write_i   memory operation in MEM
//   dmem_ack_i/req_o      data-memory handshake
//   *_Write_o             per-stage register enables
//   IF_ID_Flush_o         IF/ID loads a NOP
//   ID_EX_Bubble_o        ID/EX loads a NOP
//   MEM_WB_Bubble_o       MEM/WB loads WB=0
//   err_o                 sticky memory timeout
//   stall_cnt_o           saturating stall-cycle counter
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TO_W        = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_RsAddr_i,
    input  logic [4:0]       ID_RtAddr_i,
    input  logic             ID_UsesRt_i,
    input  logic             EX_MemRead_i,
    input  logic [4:0]       EX_RdAddr_i,
    input  logic             ID_Branch_Taken_i,
    input  logic             MEM_MemRead_i,
    input  logic             MEM_MemWrite_i,
    input  logic             dmem_ack_i,
    output logic             dmem_req_o,
    output logic             PC_Write_o,
    output logic             IF_ID_Write_o,
    output logic             IF_ID_Flush_o,
    output logic             ID_EX_Bubble_o,
    output logic             EX_MEM_Write_o,
    output logic             MEM_WB_Write_o,
    output logic             MEM_WB_Bubble_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {StRun, StMemWait, StErr} state_e;

    state_e            state_q, state_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic memop;
    logic load_use_hit;
    logic stall;
    logic req, pc_w, ifid_w, ifid_fl, idex_bub, exmem_w, memwb_w, memwb_bub;

    assign memop = MEM_MemRead_i | MEM_MemWrite_i;

    assign load_use_hit = EX_MemRead_i && (EX_RdAddr_i != 5'd0) &&
                          ((EX_RdAddr_i == ID_RsAddr_i) ||
                           (ID_UsesRt_i && (EX_RdAddr_i == ID_RtAddr_i)));

    always_comb begin
        state_d   = state_q;
        to_d      = to_q;
        err_d     = err_q;
        stall     = 1'b0;
        req       = 1'b0;
        pc_w      = 1'b1;
        ifid_w    = 1'b1;
        ifid_fl   = 1'b0;
        idex_bub  = 1'b0;
        exmem_w   = 1'b1;
        memwb_w   = 1'b1;
        memwb_bub = 1'b0;

        unique case (state_q)
            StRun: begin
                if (memop && !dmem_ack_i) begin
                    // Miss on first request: freeze front end, drain WB with a bubble.
                    req       = 1'b1;
                    stall     = 1'b1;
                    pc_w      = 1'b0;
                    ifid_w    = 1'b0;
                    exmem_w   = 1'b0;
                    memwb_bub = 1'b1;
                    state_d   = StMemWait;
                    to_d      = TO_W'(1);
                end else begin
                    // Zero-wait access (or no access): hazard logic applies normally.
                    req = memop;
                    if (load_use_hit) begin
                        stall    = 1'b1;
                        pc_w     = 1'b0;
                        ifid_w   = 1'b0;
                        idex_bub = 1'b1;
                    end else if (ID_Branch_Taken_i) begin
                        ifid_fl = 1'b1;
                    end
                end
            end
            StMemWait: begin
                req = 1'b1;
                if (dmem_ack_i) begin
                    // Ack beats timeout: release everything, MEM/WB captures the data.
                    state_d = StRun;
                    to_d    = '0;
                end else begin
                    stall     = 1'b1;
                    pc_w      = 1'b0;
                    ifid_w    = 1'b0;
                    exmem_w   = 1'b0;
                    memwb_bub = 1'b1;
                    if (to_q == TO_W'(MEM_TIMEOUT)) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end else begin
                        to_d = to_q + 1'b1;
                    end
                end
            end
            StErr: begin
                pc_w    = 1'b0;
                ifid_w  = 1'b0;
                exmem_w = 1'b0;
                memwb_w = 1'b0;
            end
            default: begin
                state_d = StRun;
            end
        endcase

        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StRun;
            to_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Every control output is held inactive while reset is asserted.
    assign dmem_req_o      = rst_i & req;
    assign PC_Write_o      = rst_i & pc_w;
    assign IF_ID_Write_o   = rst_i & ifid_w;
    assign IF_ID_Flush_o   = rst_i & ifid_fl;
    assign ID_EX_Bubble_o  = rst_i & idex_bub;
    assign EX_MEM_Write_o  = rst_i & exmem_w;
    assign MEM_WB_Write_o  = rst_i & memwb_w;
    assign MEM_WB_Bubble_o = rst_i & memwb_bub;
    assign err_o           = rst_i & err_q;
    assign stall_cnt_o     = cnt_q;

endmodule
